// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the McCoy fetch stage: opcode map, FSM encoding, default widths.
package fetch_unit_pkg;

    localparam int DEF_PC_W    = 5;
    localparam int DEF_INSTR_W = 8;

    typedef enum logic [2:0] {
        OP_BEZ = 3'b000,
        OP_LI  = 3'b001,
        OP_ADD = 3'b011,
        OP_JA  = 3'b100,
        OP_LR  = 3'b101,
        OP_SR  = 3'b110,
        OP_NOT = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/valid channel between the fetch unit (master) and memory (slave).
interface fetch_unit_if #(
    parameter int PC_W    = 5,
    parameter int INSTR_W = 8
) ();
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic [INSTR_W-1:0] mem_data;
    logic               mem_valid;

    modport master (output mem_req, output mem_addr, input  mem_data, input  mem_valid);
    modport slave  (input  mem_req, input  mem_addr, output mem_data, output mem_valid);
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC select: jump, taken branch-if-zero, or sequential increment.
module fetch_unit_pc_next
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = DEF_PC_W
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] imm,
    input  logic            ja,
    input  logic            bez,
    input  logic            x8_zero,
    output logic [PC_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc + PC_W'(1);
        if (ja || (bez && x8_zero)) next_pc = imm;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch/sequencing stage: PC, IR, retire counter and the IDLE/FETCH/EXEC control FSM.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    fetch_unit_if.master    mem,
    output logic [2:0]      opcode,
    output logic [4:0]      imm,
    output logic            exec_en,
    input  logic            ja,
    input  logic            bez,
    input  logic            x8_zero,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      retired
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [7:0]         retired_q, retired_d;
    logic [PC_W-1:0]    next_pc;

    fetch_unit_pc_next #(.PC_W(PC_W)) u_pc_next (
        .pc      (pc_q),
        .imm     (PC_W'(ir_q[4:0])),
        .ja      (ja),
        .bez     (bez),
        .x8_zero (x8_zero),
        .next_pc (next_pc)
    );

    // Request is decoded straight from the state flop so async reset drops it at once.
    assign mem.mem_req  = (state_q == ST_FETCH);
    assign mem.mem_addr = pc_q;
    assign opcode       = ir_q[7:5];
    assign imm          = ir_q[4:0];
    assign pc           = pc_q;
    assign retired      = retired_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        exec_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem.mem_valid) begin
                    ir_d    = mem.mem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                exec_en   = 1'b1;
                pc_d      = next_pc;
                retired_d = retired_q + 8'd1;
                state_d   = run ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and sequencing stage directly upstream of the opcode decoder in the McCoy 8-bit core. Holds the program counter and instruction register, fetches one 8-bit instruction per step over a request/valid handshake to external instruction memory, and presents the opcode and immediate to the decoder. It pulses an execute strobe for the datapath. It consumes the decoder's `ja`/`bez` outputs plus the datapath's x8-zero flag to select the next PC.

## Interface

Parameters:
- `PC_W`, 5, program-counter / instruction-address width (32-instruction space).
- `INSTR_W`, 8, instruction width; opcode is bits [7:5], immediate is bits [4:0].

Ports:
- `clk`  in  1  single core clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 = execute program, 0 = halt after current instruction.
- `mem_req`  out  1  instruction fetch request.
- `mem_addr`  out  PC_W  fetch address; equals `pc` while `mem_req`=1.
- `mem_data`  in  INSTR_W  instruction returned by memory.
- `mem_valid`  in  1  `mem_data` valid this cycle.
- `opcode`  out  3  IR[7:5], to decoder.
- `imm`  out  5  IR[4:0], to datapath and branch target.
- `exec_en`  out  1  one-cycle strobe; datapath/register writes are enabled only when high.
- `ja`  in  1  from decoder: unconditional jump.
- `bez`  in  1  from decoder: branch if x8 == 0.
- `x8_zero`  in  1  from datapath: x8 == 0.
- `pc`  out  PC_W  current program counter.
- `retired`  out  8  count of executed instructions (debug).

## Operation

- States: IDLE, FETCH, EXEC.
- IDLE: `mem_req`=0, `exec_en`=0. Moves to FETCH when `run`=1.
- FETCH: `mem_req`=1, `mem_addr`=`pc`. Stays in FETCH until `mem_valid`=1. On that edge, IR <= `mem_data` and the state moves to EXEC. `mem_valid` is ignored in IDLE and EXEC.
- EXEC: `exec_en`=1 for exactly one cycle. On that edge:
  - `pc` <= next_pc.
  - `retired` <= `retired`+1, wrapping 255 -> 0.
  - State goes to FETCH if `run`=1, otherwise to IDLE.
- next_pc priority:
  - `ja` -> `imm`.
  - else `bez` && `x8_zero` -> `imm`.
  - else `pc`+1, modulo 2^PC_W, so 31 wraps to 0.
- `ja`, `bez` and `x8_zero` are sampled only in EXEC. They are combinational from the current IR and x8 value, with no extra register.
- Deasserting `run` mid-FETCH does not abandon the request. The fetch completes, the instruction executes, and the unit then enters IDLE.
- Reasserting `run` in IDLE resumes at the held `pc`. A halt is not a reset.

## Timing

- Reset values (asynchronous):
  - state = IDLE, `pc`=0, IR=0, `retired`=0.
  - `mem_req`=0, `mem_addr`=0, `opcode`=0, `imm`=0, `exec_en`=0.
  - Assertion mid-fetch drops `mem_req` immediately, without waiting for a clock edge.
- Memory latency is arbitrary, 0..N cycles. `mem_valid` may be high in the same cycle `mem_req` first rises.
- Minimum throughput is one instruction per 2 cycles: 1 FETCH cycle + 1 EXEC cycle.
- `opcode`/`imm` are stable from the EXEC cycle until the next IR load. They are registered outputs, so the decoder sees them glitch-free.
- `mem_req` and `exec_en` are never high in the same cycle.
- A branch target is visible on `mem_addr` in the first FETCH cycle after EXEC. There are no delay slots.

## Structure

- Shared package holds:
  - Opcode constants: BEZ=000, LI=001, ADD=011, JA=100, LR=101, SR=110, NOT=111.
  - State encoding.
  - `PC_W` and `INSTR_W` defaults.
- Natural sub-module: `pc_next`, combinational next-PC mux (pc, imm, ja, bez, x8_zero -> next_pc).
- FSM, IR, PC and `retired` registers live in `fetch_unit`.

## Test plan

- Reset then `run`=1, memory returns `mem_valid` with 0-cycle latency, 3 instructions of opcode 011 -> `pc` goes 0,1,2,3; `exec_en` every 2nd cycle; `retired`=3.
- Jump: `ja`=1 at pc=4 with imm=0x1A (`mem_data`=0x9A) -> next `mem_addr`=26. Then `ja`=1 at pc=31 -> target, no wrap effect. Straight-line execution at pc=31 -> `pc` wraps to 0.
- Branch: `bez`=1, imm=7 with `x8_zero`=1 -> `pc`=7. Same with `x8_zero`=0 -> `pc`=old+1.
- Variable latency: `mem_valid` delayed 5 cycles -> `mem_req` held 6 cycles, `mem_addr` stable, `exec_en` not asserted until after valid. A spurious `mem_valid` in IDLE/EXEC -> IR unchanged.
- Halt: drop `run` during FETCH -> instruction still executes once, then IDLE with `mem_req`=0. Raise `run` -> fetch resumes at the held pc.
- Async reset asserted mid-FETCH, between edges -> `mem_req` falls immediately, `pc`=0, `retired`=0. After release with `run`=1 -> fetch from address 0.
